// File: rtl/dram_rd_pkg.sv
// Shared widths and the read-FIFO entry layout for the DRAM read capture path.
package dram_rd_pkg;
   localparam int DATA_W  = 256;
   localparam int ECC_W   = 32;
   localparam int ENTRY_W = 1 + ECC_W + DATA_W;

   typedef struct packed {
      logic              beat;
      logic [ECC_W-1:0]  ecc;
      logic [DATA_W-1:0] data;
   } rd_entry_t;
endpackage

// File: rtl/dram_rd_capture_if.sv
// Pad-side read beat inputs and consumer-side FIFO head outputs.
interface dram_rd_capture_if
   import dram_rd_pkg::*;
#(
   parameter int CNT_W = 3
);
   logic              io_dram_data_valid_buf;
   logic [DATA_W-1:0] io_dram_data_in_buf;
   logic [ECC_W-1:0]  io_dram_ecc_in_buf;
   logic              rd_rdy;
   logic              ovf_clr;
   logic              rd_vld;
   logic [DATA_W-1:0] rd_data;
   logic [ECC_W-1:0]  rd_ecc;
   logic              rd_beat;
   logic [CNT_W-1:0]  rd_cnt;
   logic              rd_ovf;

   modport master (
      output io_dram_data_valid_buf,
      output io_dram_data_in_buf,
      output io_dram_ecc_in_buf,
      output rd_rdy,
      output ovf_clr,
      input  rd_vld,
      input  rd_data,
      input  rd_ecc,
      input  rd_beat,
      input  rd_cnt,
      input  rd_ovf
   );

   modport slave (
      input  io_dram_data_valid_buf,
      input  io_dram_data_in_buf,
      input  io_dram_ecc_in_buf,
      input  rd_rdy,
      input  ovf_clr,
      output rd_vld,
      output rd_data,
      output rd_ecc,
      output rd_beat,
      output rd_cnt,
      output rd_ovf
   );
endinterface

// File: rtl/dram_rd_fifo.sv
// First-word-fall-through read FIFO: storage, pointers and occupancy.
module dram_rd_fifo
   import dram_rd_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             push_vld,
   input  rd_entry_t        push_entry,
   input  logic             pop_rdy,
   output logic             head_vld,
   output rd_entry_t        head_entry,
   output logic             full,
   output logic [CNT_W-1:0] cnt
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   rd_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push;
   logic             pop;

   assign full       = (cnt_q == CNT_W'(DEPTH));
   assign head_vld   = (cnt_q != '0);
   assign pop        = head_vld & pop_rdy;
   // A full FIFO still takes a beat when the head leaves in the same cycle.
   assign push       = push_vld & (~full | pop);
   assign head_entry = mem_q[rd_ptr_q];
   assign cnt        = cnt_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
   end
endmodule

// File: rtl/dram_rd_capture.sv
// DRAM read beat capture: beat tagging, sticky overflow, optional input
// register (DRAM_RD_CAPTURE_REG_EN) in front of the read FIFO.
module dram_rd_capture
   import dram_rd_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_l,
   dram_rd_capture_if.slave bus
);
   logic              in_vld;
   logic [DATA_W-1:0] in_data;
   logic [ECC_W-1:0]  in_ecc;
   logic              beat_q, beat_d;
   logic              ovf_q, ovf_d;
   logic              drop;
   logic              fifo_vld;
   logic              fifo_full;
   rd_entry_t         push_entry;
   rd_entry_t         head_entry;

`ifdef DRAM_RD_CAPTURE_REG_EN
   logic              in_vld_q, in_vld_d;
   logic [DATA_W-1:0] in_data_q, in_data_d;
   logic [ECC_W-1:0]  in_ecc_q, in_ecc_d;

   always_comb begin
      in_vld_d  = bus.io_dram_data_valid_buf;
      in_data_d = bus.io_dram_data_in_buf;
      in_ecc_d  = bus.io_dram_ecc_in_buf;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         in_vld_q  <= 1'b0;
         in_data_q <= '0;
         in_ecc_q  <= '0;
      end else begin
         in_vld_q  <= in_vld_d;
         in_data_q <= in_data_d;
         in_ecc_q  <= in_ecc_d;
      end
   end

   assign in_vld  = in_vld_q;
   assign in_data = in_data_q;
   assign in_ecc  = in_ecc_q;
`else
   assign in_vld  = bus.io_dram_data_valid_buf;
   assign in_data = bus.io_dram_data_in_buf;
   assign in_ecc  = bus.io_dram_ecc_in_buf;
`endif

   // Toggle on dropped beats too, so half-line tags stay aligned.
   always_comb begin
      drop   = in_vld & fifo_full & ~(fifo_vld & bus.rd_rdy);
      beat_d = beat_q ^ in_vld;
      ovf_d  = drop | (ovf_q & ~bus.ovf_clr);
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         beat_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         beat_q <= beat_d;
         ovf_q  <= ovf_d;
      end
   end

   assign push_entry = '{beat: beat_q, ecc: in_ecc, data: in_data};

   dram_rd_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .rst_l      (rst_l),
      .push_vld   (in_vld),
      .push_entry (push_entry),
      .pop_rdy    (bus.rd_rdy),
      .head_vld   (fifo_vld),
      .head_entry (head_entry),
      .full       (fifo_full),
      .cnt        (bus.rd_cnt)
   );

   assign bus.rd_vld  = fifo_vld;
   assign bus.rd_data = head_entry.data;
   assign bus.rd_ecc  = head_entry.ecc;
   assign bus.rd_beat = head_entry.beat;
   assign bus.rd_ovf  = ovf_q;
endmodule

// File: tb/tb_dram_rd_capture.sv
// Directed plus randomized bench for dram_rd_capture against a queue model.
module tb_dram_rd_capture;
   import dram_rd_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic clk;
   logic rst_l;
   int   checks;
   int   failures;

   rd_entry_t         mq[$];
   bit                mbeat;
   bit                movf;
   bit                sv;
   logic [DATA_W-1:0] sd;
   logic [ECC_W-1:0]  se;

   dram_rd_capture_if #(.CNT_W(CNT_W)) bus ();

   dram_rd_capture #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_l (rst_l),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare();
      chk("rd_vld", 256'(bus.rd_vld), 256'(mq.size() != 0));
      chk("rd_cnt", 256'(bus.rd_cnt), 256'(mq.size()));
      chk("rd_ovf", 256'(bus.rd_ovf), 256'(movf));
      if (mq.size() != 0) begin
         chk("rd_data", bus.rd_data, mq[0].data);
         chk("rd_ecc", 256'(bus.rd_ecc), 256'(mq[0].ecc));
         chk("rd_beat", 256'(bus.rd_beat), 256'(mq[0].beat));
      end
   endtask

   task automatic model_clear();
      mq.delete();
      mbeat = 1'b0;
      movf  = 1'b0;
      sv    = 1'b0;
      sd    = '0;
      se    = '0;
   endtask

   task automatic step(input bit v, input logic [DATA_W-1:0] d,
                       input logic [ECC_W-1:0] e, input bit rdy,
                       input bit clr);
      bit                iv;
      bit                pop;
      bit                dropped;
      logic [DATA_W-1:0] id;
      logic [ECC_W-1:0]  ie;
      bus.io_dram_data_valid_buf = v;
      bus.io_dram_data_in_buf    = d;
      bus.io_dram_ecc_in_buf     = e;
      bus.rd_rdy                 = rdy;
      bus.ovf_clr                = clr;
      @(posedge clk);
      iv = v;
      id = d;
      ie = e;
`ifdef DRAM_RD_CAPTURE_REG_EN
      iv = sv;
      id = sd;
      ie = se;
      sv = v;
      sd = d;
      se = e;
`endif
      pop     = (mq.size() != 0) && rdy;
      dropped = 1'b0;
      if (pop) void'(mq.pop_front());
      if (iv) begin
         if (mq.size() < DEPTH) mq.push_back('{mbeat, ie, id});
         else dropped = 1'b1;
         mbeat = ~mbeat;
      end
      if (dropped) movf = 1'b1;
      else if (clr) movf = 1'b0;
      #1;
      compare();
   endtask

   task automatic idle(input bit rdy);
      step(1'b0, '0, '0, rdy, 1'b0);
   endtask

   task automatic do_reset();
      bus.io_dram_data_valid_buf = 1'b0;
      bus.io_dram_data_in_buf    = '0;
      bus.io_dram_ecc_in_buf     = '0;
      bus.rd_rdy                 = 1'b0;
      bus.ovf_clr                = 1'b0;
      rst_l = 1'b0;
      #2;
      chk("rst_vld", 256'(bus.rd_vld), 256'(0));
      chk("rst_cnt", 256'(bus.rd_cnt), 256'(0));
      chk("rst_ovf", 256'(bus.rd_ovf), 256'(0));
      model_clear();
      @(negedge clk);
      rst_l = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DATA_W-1:0] rnd_data();
      return {8{$urandom}};
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      model_clear();

      do_reset();
      step(1'b1, 256'h1, 32'hA5, 1'b0, 1'b0);
`ifdef DRAM_RD_CAPTURE_REG_EN
      idle(1'b0);
`endif
      chk("first_vld", 256'(bus.rd_vld), 256'(1));
      chk("first_beat", 256'(bus.rd_beat), 256'(0));
      chk("first_cnt", 256'(bus.rd_cnt), 256'(1));

      do_reset();
      for (int i = 0; i < 5; i++)
         step(1'b1, 256'(i + 16), 32'(i), 1'b0, 1'b0);
      idle(1'b0);
      chk("ovf_cnt", 256'(bus.rd_cnt), 256'(DEPTH));
      chk("ovf_set", 256'(bus.rd_ovf), 256'(1));
      step(1'b0, '0, '0, 1'b0, 1'b1);
      chk("ovf_clr", 256'(bus.rd_ovf), 256'(0));
      step(1'b1, 256'hBEEF, 32'h77, 1'b1, 1'b0);
`ifdef DRAM_RD_CAPTURE_REG_EN
      idle(1'b0);
      idle(1'b1);
`endif
      chk("full_pp_cnt", 256'(bus.rd_cnt), 256'(DEPTH));
      chk("full_pp_ovf", 256'(bus.rd_ovf), 256'(0));
      for (int i = 0; i < DEPTH; i++) idle(1'b1);

      do_reset();
      for (int i = 0; i < 6; i++)
         step(1'b1, rnd_data(), $urandom, 1'b0, 1'b0);
      chk("drop_ovf", 256'(bus.rd_ovf), 256'(1));
      step(1'b1, rnd_data(), $urandom, 1'b0, 1'b1);
      chk("clr_drop_ovf", 256'(bus.rd_ovf), 256'(1));
      step(1'b0, '0, '0, 1'b0, 1'b1);
`ifdef DRAM_RD_CAPTURE_REG_EN
      step(1'b0, '0, '0, 1'b0, 1'b1);
`endif
      chk("clr_only_ovf", 256'(bus.rd_ovf), 256'(0));

      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(1'b1, rnd_data(), $urandom, 1'b1, 1'b0);
         chk("stream_cnt", 256'(bus.rd_cnt <= 1), 256'(1));
      end
      chk("stream_ovf", 256'(bus.rd_ovf), 256'(0));

      do_reset();
      for (int i = 0; i < 3; i++)
         step(1'b1, rnd_data(), $urandom, 1'b0, 1'b0);
`ifdef DRAM_RD_CAPTURE_REG_EN
      idle(1'b0);
`endif
      chk("pre_rst_cnt", 256'(bus.rd_cnt), 256'(3));
      #3;
      do_reset();
      step(1'b1, rnd_data(), $urandom, 1'b0, 1'b0);
      idle(1'b0);
      chk("post_rst_beat", 256'(bus.rd_beat), 256'(0));

      do_reset();
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, rnd_data(), $urandom,
              1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dram_rd_capture.md
DRAM_RD_CAPTURE -- requirements
Module: dram_rd_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning read FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 3, meaning occupancy width, equal to log2(DEPTH)+1.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_l  input  1  asynchronous active-low reset.
REQ-005 io_dram_data_valid_buf  input  1  pad read beat valid, from the DDR repeater.
REQ-006 io_dram_data_in_buf  input  256  pad read data beat.
REQ-007 io_dram_ecc_in_buf  input  32  pad read ECC beat.
REQ-008 rd_rdy  input  1  consumer ready; pop when rd_vld&&rd_rdy.
REQ-009 ovf_clr  input  1  clears sticky overflow.
REQ-010 rd_vld  output  1  FIFO head valid (FIFO not empty).
REQ-011 rd_data  output  256  head data.
REQ-012 rd_ecc  output  32  head ECC.
REQ-013 rd_beat  output  1  head beat index within 64B line (0 first half, 1 second half).
REQ-014 rd_cnt  output  CNT_W  current occupancy.
REQ-015 rd_ovf  output  1  sticky overflow, beat dropped.

Function
REQ-016 Push condition SHALL be: valid beat at FIFO input && (not full || pop same cycle).
REQ-017 A pushed entry SHALL hold {beat, ecc, data}, written at write pointer; write pointer increments mod DEPTH.
REQ-018 Output SHALL be first-word-fall-through: rd_data/rd_ecc/rd_beat driven combinationally from read-pointer entry; read pointer increments mod DEPTH on pop.
REQ-019 Latency SHALL be 1 cycle without macro: valid sampled at edge N -> rd_vld high after edge N.
REQ-020 rd_cnt: +1 push only, -1 pop only, unchanged on push+pop or neither; never exceeds DEPTH, never underflows.
REQ-021 Full (rd_cnt==DEPTH) with valid and no pop SHALL drop the beat, leave FIFO unchanged, and set rd_ovf on the next edge.
REQ-022 Full with valid and pop in the same cycle SHALL accept the beat; rd_cnt stays DEPTH; rd_ovf not set.
REQ-023 Empty with valid and rd_rdy: no bypass; pop ignored since rd_vld=0; entry visible next cycle.
REQ-024 Beat toggle SHALL flip on every input valid, including dropped beats, so line alignment survives overflow.
REQ-025 rd_ovf SHALL stay high until ovf_clr; set and clear in the same cycle -> set wins.
REQ-026 When rd_vld=0, rd_data/rd_ecc/rd_beat SHALL be don't-care; the bench SHALL NOT check them.

Reset
REQ-027 On rst_l low, immediately and independent of clk: pointers=0, rd_cnt=0, rd_vld=0, beat toggle=0, rd_ovf=0, input stage (if present) valid=0.
REQ-028 Reset mid-burst SHALL discard all entries; first valid after release is tagged beat 0.
REQ-029 FIFO storage array SHALL NOT be reset.

Configuration
REQ-030 Macro DRAM_RD_CAPTURE_REG_EN defined SHALL insert one input register on valid/data/ecc (valid reset to 0), making latency 2 cycles; all boundary rules apply at the registered point.
REQ-031 Macro DRAM_RD_CAPTURE_REG_EN undefined SHALL feed pad inputs directly to push logic, giving 1-cycle latency.

Structure
REQ-032 Package dram_rd_pkg SHALL hold DATA_W=256, ECC_W=32, ENTRY_W=289, and the entry struct typedef {beat, ecc, data}.
REQ-033 Storage, pointers and count SHALL live in sub-module dram_rd_fifo; beat toggle, overflow and optional input stage SHALL live in the top.

Verification
REQ-034 Reset, then single beat data=256'h1, ecc=32'hA5, rd_rdy=0 -> rd_vld=1 after 1 edge (2 with macro), rd_beat=0, rd_cnt=1.
REQ-035 Five consecutive beats, rd_rdy=0, DEPTH=4 -> rd_cnt=4, fifth dropped, rd_ovf=1, stored beats tagged 0,1,0,1; next accepted beat tagged 1.
REQ-036 Full FIFO, valid and rd_rdy same cycle -> pop of entry0 and push of new beat, rd_cnt stays 4, rd_ovf=0.
REQ-037 Continuous valid with rd_rdy=1 for 16 cycles -> rd_cnt<=1, data in order, no overflow, pointers wrap cleanly.
REQ-038 rst_l asserted mid-clock with rd_cnt=3 -> rd_vld=0, rd_cnt=0 immediately; next beat after release tagged 0.
REQ-039 rd_ovf=1 with ovf_clr and a new drop in the same cycle -> rd_ovf remains 1; ovf_clr alone next cycle -> 0.
